dmem_byte_loader: RTL and testbench
===================================

// Module: dmem_byte_loader
// PURPOSE
//  Byte-stream loader sitting directly upstream of the data memory's port.
//  Takes a valid/ready byte stream (e.g. UART RX, host image upload) and writes
//  it into data memory, one byte per cycle, using byte-enable stores at
//  consecutive byte addresses from a programmed base.
//  While idle it passes the CPU's memory signals straight through to dmem.
//  While loading it owns the port and stalls the CPU.
// PARAMETERS
//  MEM_WORDS  64  dmem depth in 32-bit words; the legal byte range is 0 .. MEM_WORDS*4-1
//  LEN_W      16  width of the transfer length, in bytes
// PORTS
//  clk        in   1      rising-edge clock, shared with dmem
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      1-cycle request; sampled only in IDLE
//  abort      in   1      cancels an active transfer
//  base_addr  in   32     byte address of the first byte; sampled with start
//  length     in   LEN_W  number of bytes; sampled with start
//  in_valid   in   1      stream byte valid
//  in_data    in   8      stream byte
//  in_ready   out  1      loader accepts a byte this cycle
//  cpu_we     in   1      CPU store enable (pass-through source)
//  cpu_be     in   1      CPU byte-mode flag (pass-through source)
//  cpu_a      in   32     CPU address (pass-through source)
//  cpu_wd     in   32     CPU write data (pass-through source)
//  mem_we     out  1      to dmem we
//  mem_be     out  1      to dmem be
//  mem_a      out  32     to dmem a
//  mem_wd     out  32     to dmem wd
//  cpu_stall  out  1      high while the loader owns the memory port
//  busy       out  1      state == RUN
//  done       out  1      1-cycle pulse when a transfer completes normally
//  err        out  1      1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset values (async, rst_n low): state=IDLE, offset=0, busy=0, done=0,
//   err=0, in_ready=0, cpu_stall=0; mem_* = cpu_* (combinational).
//  FSM states: IDLE, RUN, FIN.
//  IDLE
//   - mem_*=cpu_*; in_ready=0.
//   - start & !abort & length!=0 & in range -> latch base and length, offset=0, go to RUN.
//   - In range means base_addr + length <= MEM_WORDS*4, computed 33 bits wide with
//     no wrap. Out of range -> err=1 for the next cycle, stay in IDLE, no write.
//   - start & length==0 -> done=1 for the next cycle, stay in IDLE, no write.
//   - start & abort in the same cycle -> abort wins; start is ignored.
//  RUN
//   - busy=1, cpu_stall=1, in_ready=1; the CPU's memory signals are ignored.
//   - A byte is accepted on a cycle with in_valid & in_ready.
//   - For an accepted byte, this cycle, combinationally: mem_we=1, mem_be=1,
//     mem_a=base+offset, mem_wd={24'd0,in_data}. dmem commits it at the next posedge.
//   - With no accepted byte: mem_we=0, mem_be=0, mem_a=base+offset, mem_wd=0.
//   - offset increments by 1 per accepted byte. The accept with offset==length-1 -> go to FIN.
//   - abort -> go to IDLE on the next edge; a byte accepted in the same cycle is still
//     written; done is not pulsed; bytes already written stay in memory.
//   - start is ignored while in RUN.
//  FIN (1 cycle)
//   - done=1, busy=0, in_ready=0, cpu_stall=1, mem_we=0; then go to IDLE.
//  Throughput: 1 byte/cycle. Latency from the accept cycle to the byte in RAM: 1 edge.
//  Reset mid-transfer: return to IDLE immediately; bytes already written are not undone.
// TESTING
//  1. base=0x10, len=4, stream AA BB CC DD back-to-back
//     -> 4 writes in 4 cycles; RAM[4]=0xDDCCBBAA; done pulses the cycle after the 4th accept.
//  2. Same as 1, with in_valid low for 3 cycles after byte 2
//     -> no writes during the gap (mem_we=0); final RAM contents identical to scenario 1.
//  3. base=0xFE, len=4 with MEM_WORDS=64 (0x102 > 0x100)
//     -> err pulse, no mem_we, state stays IDLE. len=0 -> done pulse only.
//  4. abort asserted after 2 of 8 bytes
//     -> exactly 2 bytes written, no done, CPU pass-through restored on the next cycle.
//  5. rst_n low mid-transfer, then a new start
//     -> outputs take their reset values asynchronously; the new transfer starts at offset 0.
//  6. IDLE with cpu_we=1, cpu_be=0, cpu_a=8, cpu_wd=0x12345678
//     -> mem_* mirror cpu_* in the same cycle; RAM[2]=0x12345678.

Source files
------------

// File: rtl/dmem_byte_loader_if.sv
// Byte-stream and memory-port bundle for dmem_byte_loader.
// The slave side is the loader; the master side is its environment.
interface dmem_byte_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cpu_we;
  logic        cpu_be;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic        mem_we;
  logic        mem_be;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;

  modport slave (
    input  in_valid, in_data, cpu_we, cpu_be, cpu_a, cpu_wd,
    output in_ready, mem_we, mem_be, mem_a, mem_wd
  );

  modport master (
    output in_valid, in_data, cpu_we, cpu_be, cpu_a, cpu_wd,
    input  in_ready, mem_we, mem_be, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_byte_loader.sv
// Streams bytes into data memory with byte-enable stores from a programmed base;
// passes the CPU's memory port through while idle.
module dmem_byte_loader #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  dmem_byte_loader_if.slave bus,
  output logic             cpu_stall,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] off_q;
  logic             in_ready_q;
  logic [32:0]      end_addr;
  logic             in_range;
  logic             start_req;
  logic             launch;
  logic             accept;
  logic             last;

  // Range check is 33 bits wide so base+length never wraps into range.
  assign end_addr  = {1'b0, base_addr} + 33'(length);
  assign in_range  = (end_addr <= 33'(MEM_BYTES));
  assign start_req = (state_q == IDLE) && start && !abort;
  assign launch    = start_req && (length != '0) && in_range;
  assign accept    = (state_q == RUN) && bus.in_valid;
  assign last      = (off_q == LEN_W'(len_q - LEN_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort beats a final accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN: begin
        if (abort)                state_d = IDLE;
        else if (accept && last)  state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer context and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      cpu_stall  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (launch) begin
        base_q <= base_addr;
        len_q  <= length;
        off_q  <= '0;
      end else if (accept) begin
        off_q  <= off_q + LEN_W'(1);
      end
      in_ready_q <= (state_d == RUN);
      busy       <= (state_d == RUN);
      cpu_stall  <= (state_d != IDLE);
      done       <= (state_d == FIN) || (start_req && (length == '0));
      err        <= start_req && (length != '0) && !in_range;
    end
  end

  assign bus.in_ready = in_ready_q;

  // Memory port mux: CPU pass-through in IDLE, loader-owned otherwise
  always_comb begin
    bus.mem_we = 1'b0;
    bus.mem_be = 1'b0;
    bus.mem_a  = base_q + 32'(off_q);
    bus.mem_wd = '0;
    if (state_q == IDLE) begin
      bus.mem_we = bus.cpu_we;
      bus.mem_be = bus.cpu_be;
      bus.mem_a  = bus.cpu_a;
      bus.mem_wd = bus.cpu_wd;
    end else if (accept) begin
      bus.mem_we = 1'b1;
      bus.mem_be = 1'b1;
      bus.mem_wd = {24'd0, bus.in_data};
    end
  end

endmodule

// File: tb/tb_dmem_byte_loader.sv
// Directed and randomized bench for dmem_byte_loader with a byte-array reference
// memory and a simple dmem behavioural model on the loader's memory port.
module tb_dmem_byte_loader;

  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] length;
  logic             cpu_stall;
  logic             busy;
  logic             done;
  logic             err;

  dmem_byte_loader_if bus ();

  dmem_byte_loader #(.MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .bus       (bus),
    .cpu_stall (cpu_stall),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dmem behavioural model: byte store into the addressed lane, or full word store
  logic [31:0] ram [MEM_WORDS] = '{default: 32'd0};
  always @(posedge clk) begin
    if (bus.mem_we && (bus.mem_a < 32'(MEM_BYTES))) begin
      if (bus.mem_be) ram[bus.mem_a[7:2]][8*bus.mem_a[1:0] +: 8] <= bus.mem_wd[7:0];
      else            ram[bus.mem_a[7:2]] <= bus.mem_wd;
    end
  end

  // Reference: expected contents as a flat byte array
  logic [7:0] exp_mem [MEM_BYTES] = '{default: 8'd0};
  logic [7:0] src [$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {exp_mem[4*w+3], exp_mem[4*w+2], exp_mem[4*w+1], exp_mem[4*w]};
  endfunction

  // mode 0: back-to-back, 1: 3-cycle gap after byte 2, 2: random gaps.
  // stop_at >= 0 interrupts after that many accepted bytes (abort or reset).
  task automatic run_xfer(input int b, input int n, input int mode, input int stop_at,
                          input bit use_reset, input bit abort_valid);
    int idx = 0;
    int cyc = 0;
    int gap = 0;
    bit v;
    @(negedge clk);
    start = 1'b1; base_addr = 32'(b); length = LEN_W'(n); bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("start_busy", 32'(busy), 32'd1);
    check("start_rdy",  32'(bus.in_ready), 32'd1);
    check("start_stall", 32'(cpu_stall), 32'd1);
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      start = 1'b0; cyc++;
      bus.cpu_we = 1'($urandom_range(0, 1));
      bus.cpu_a = $urandom; bus.cpu_wd = $urandom;
      if (idx == stop_at) begin
        if (use_reset) begin
          bus.cpu_we = 1'b0; bus.in_valid = 1'b0; bus.cpu_a = 32'h0000_00C4;
          rst_n = 1'b0; #1;
          check("rst_busy",  32'(busy), 32'd0);
          check("rst_stall", 32'(cpu_stall), 32'd0);
          check("rst_rdy",   32'(bus.in_ready), 32'd0);
          check("rst_pass_a", bus.mem_a, 32'h0000_00C4);
          @(negedge clk); rst_n = 1'b1;
          return;
        end
        abort = 1'b1;
        bus.in_valid = abort_valid ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_data = 8'($urandom);
        v = bus.in_valid;
        #1;
        check("abort_we", 32'(bus.mem_we), 32'(v));
        @(posedge clk);
        if (v) exp_mem[b + idx] = bus.in_data;
        #1;
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_stall", 32'(cpu_stall), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        @(negedge clk);
        abort = 1'b0; bus.in_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = 32'h0000_0099;
        #1;
        check("abort_pass_a", bus.mem_a, 32'h0000_0099);
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1: begin
          v = !(idx == 2 && gap < 3);
          if (!v) gap++;
        end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = (idx < src.size()) ? src[idx] : 8'($urandom);
      #1;
      check("run_we", 32'(bus.mem_we), 32'(v));
      if (v) begin
        check("run_a",  bus.mem_a, 32'(b + idx));
        check("run_wd", bus.mem_wd, {24'd0, bus.in_data});
        check("run_be", 32'(bus.mem_be), 32'd1);
      end
      @(posedge clk);
      if (v) begin
        exp_mem[b + idx] = bus.in_data;
        idx++;
      end
      #1;
      if (idx < n) begin
        check("run_busy", 32'(busy), 32'd1);
      end else begin
        check("fin_done",  32'(done), 32'd1);
        check("fin_busy",  32'(busy), 32'd0);
        check("fin_stall", 32'(cpu_stall), 32'd1);
        check("fin_rdy",   32'(bus.in_ready), 32'd0);
      end
    end
    if (idx < n) check("xfer_timeout", 32'(idx), 32'(n));
    @(negedge clk);
    bus.in_valid = 1'b0; bus.cpu_we = 1'b0;
    #1;
    check("fin_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    check("post_done",  32'(done), 32'd0);
    check("post_stall", 32'(cpu_stall), 32'd0);
  endtask

  initial begin
    int b;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.cpu_we = 1'b0; bus.cpu_be = 1'b0; bus.cpu_a = 32'h0000_0033; bus.cpu_wd = '0;
    #2;
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_done",  32'(done), 32'd0);
    check("reset_err",   32'(err), 32'd0);
    check("reset_rdy",   32'(bus.in_ready), 32'd0);
    check("reset_stall", 32'(cpu_stall), 32'd0);
    check("reset_pass_a", bus.mem_a, 32'h0000_0033);
    @(negedge clk); rst_n = 1'b1;

    // CPU pass-through word store
    @(negedge clk);
    bus.cpu_we = 1'b1; bus.cpu_be = 1'b0; bus.cpu_a = 32'd8; bus.cpu_wd = 32'h1234_5678;
    #1;
    check("pass_we", 32'(bus.mem_we), 32'd1);
    check("pass_be", 32'(bus.mem_be), 32'd0);
    check("pass_a",  bus.mem_a, 32'd8);
    check("pass_wd", bus.mem_wd, 32'h1234_5678);
    @(posedge clk);
    {exp_mem[11], exp_mem[10], exp_mem[9], exp_mem[8]} = 32'h1234_5678;
    #1;
    check("pass_ram2", ram[2], 32'h1234_5678);
    @(negedge clk); bus.cpu_we = 1'b0;

    // Back-to-back load, then the same with a gap
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_xfer(32'h10, 4, 0, -1, 1'b0, 1'b0);
    check("s1_ram4", ram[4], 32'hDDCC_BBAA);
    ram[4] = 32'd0;
    run_xfer(32'h10, 4, 1, -1, 1'b0, 1'b0);
    check("s2_ram4", ram[4], 32'hDDCC_BBAA);
    src = {};

    // Out-of-range start, then zero-length start
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_00FE; length = LEN_W'(4);
    #1;
    check("oor_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    check("oor_err",  32'(err), 32'd1);
    check("oor_busy", 32'(busy), 32'd0);
    check("oor_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_0020; length = '0;
    @(posedge clk); #1;
    check("zero_done", 32'(done), 32'd1);
    check("zero_err",  32'(err), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("zero_done_clr", 32'(done), 32'd0);

    // start with abort in the same cycle is ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = 32'h20; length = LEN_W'(4);
    @(posedge clk); #1;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_done", 32'(done), 32'd0);
    @(negedge clk); start = 1'b0; abort = 1'b0;

    // Exactly reaching the top of memory is legal
    run_xfer(32'hFC, 4, 0, -1, 1'b0, 1'b0);

    // Abort after 2 of 8, reset mid-transfer, then a fresh transfer
    run_xfer(32'h40, 8, 0, 2, 1'b0, 1'b0);
    run_xfer(32'h80, 6, 0, 3, 1'b1, 1'b0);
    run_xfer(32'h80, 2, 0, -1, 1'b0, 1'b0);

    // Randomized transfers, some aborted
    for (int t = 0; t < 10; t++) begin
      b = int'($urandom_range(0, MEM_BYTES - 1));
      n = int'($urandom_range(1, (MEM_BYTES - b) < 12 ? (MEM_BYTES - b) : 12));
      run_xfer(b, n, 2, (t % 4 == 3) ? int'($urandom_range(0, n - 1)) : -1, 1'b0, 1'b1);
    end

    @(negedge clk);
    for (int w = 0; w < int'(MEM_WORDS); w++) check($sformatf("ram[%0d]", w), ram[w], exp_word(w));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
